// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Produces sync, blanking, display enable, pixel coordinates, line/frame
// strobes and a frame counter, with an optional clock-enable divider so the
// pixel rate can run below clk_sys.
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN adds r/g/b colour-bar
// outputs registered alongside the timing outputs.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CE_DIV   = 1,
   parameter int CW       = 12
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          en,
   output logic          pix_ce,
   output logic          hs,
   output logic          vs,
   output logic          hblank,
   output logic          vblank,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start,
   output logic [15:0]   frame_cnt
`ifdef VGA_TIMING_TEST_PATTERN_EN
   ,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [DW-1:0] r_div;
   logic [CW-1:0] r_hCnt;
   logic [CW-1:0] r_vCnt;
   logic          r_frameSeen;

   logic w_ce;
   logic w_hEnd;
   logic w_vEnd;
   logic w_hBlank;
   logic w_vBlank;
   logic w_hsAct;
   logic w_vsAct;
   logic w_lineStart;
   logic w_frameStart;

   assign w_ce         = en && (r_div == DIV_LAST);
   assign w_hEnd       = (r_hCnt == H_LAST);
   assign w_vEnd       = (r_vCnt == V_LAST);
   assign w_hBlank     = (r_hCnt >= H_ACT_C);
   assign w_vBlank     = (r_vCnt >= V_ACT_C);
   assign w_hsAct      = (r_hCnt >= HS_BEGIN) && (r_hCnt < HS_END);
   assign w_vsAct      = (r_vCnt >= VS_BEGIN) && (r_vCnt < VS_END);
   assign w_lineStart  = (r_hCnt == '0);
   assign w_frameStart = w_lineStart && (r_vCnt == '0);

`ifdef VGA_TIMING_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
   localparam logic [CW-1:0] BAR_C = CW'(BAR_W);

   logic [2:0] w_bar;
   logic       w_de;

   assign w_bar = 3'(r_hCnt / BAR_C);
   assign w_de  = !w_hBlank && !w_vBlank;
`endif

   // Pixel divider and raster position; everything freezes while en is low.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_div  <= '0;
         r_hCnt <= '0;
         r_vCnt <= '0;
      end else if (en) begin
         if (w_ce) begin
            r_div <= '0;
            if (w_hEnd) begin
               r_hCnt <= '0;
               if (w_vEnd) begin
                  r_vCnt <= '0;
               end else begin
                  r_vCnt <= r_vCnt + CW'(1);
               end
            end else begin
               r_hCnt <= r_hCnt + CW'(1);
            end
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

   // Present the pixel at the current position one clock later; strobes last one cycle.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         pix_ce      <= 1'b0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         hblank      <= 1'b1;
         vblank      <= 1'b1;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
         r_frameSeen <= 1'b0;
      end else if (w_ce) begin
         pix_ce      <= 1'b1;
         hs          <= w_hsAct ? HS_POL : ~HS_POL;
         vs          <= w_vsAct ? VS_POL : ~VS_POL;
         hblank      <= w_hBlank;
         vblank      <= w_vBlank;
         de          <= !w_hBlank && !w_vBlank;
         x           <= r_hCnt;
         y           <= r_vCnt;
         line_start  <= w_lineStart;
         frame_start <= w_frameStart;
         if (w_frameStart) begin
            r_frameSeen <= 1'b1;
            if (r_frameSeen) begin
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
      end else begin
         pix_ce      <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

`ifdef VGA_TIMING_TEST_PATTERN_EN
   // Eight vertical colour bars in the active area, black during blanking.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r <= 8'h00;
         g <= 8'h00;
         b <= 8'h00;
      end else if (w_ce) begin
         r <= (w_de && w_bar[2]) ? 8'hFF : 8'h00;
         g <= (w_de && w_bar[1]) ? 8'hFF : 8'h00;
         b <= (w_de && w_bar[0]) ? 8'hFF : 8'h00;
      end
   end
`endif

endmodule
